bip_control: RTL

Control unit for the accumulator processor. It holds the program counter and fetches 16-bit instructions from program memory. It decodes each instruction into the select, operation and write-enable strobes that drive the accumulator datapath, and into the data-memory read/write strobes. It sits directly upstream of the datapath and supplies its operand field, `sel_A`, `sel_B`, `i_op` and `w_acc`.

---
 rtl/bip_control_if.sv | 54 +++++
 rtl/bip_control.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bip_control_if.sv
// Bus between the bip_control unit and its neighbours (program memory and accumulator datapath).
// Signals:
//   i_start     - leaves IDLE to begin execution
//   i_Instr     - instruction word read combinationally from program memory at o_Addr_prog
//   o_Addr_prog - program counter
//   o_Data      - operand field of the current instruction
//   o_sel_A     - accumulator source select (00 RAM, 01 sign-extended operand, 10 ALU)
//   o_sel_B     - ALU operand B select (0 RAM, 1 sign-extended operand)
//   o_op        - ALU operation (0 add, 1 subtract)
//   o_w_acc     - accumulator write enable
//   o_wr_ram    - data-memory write strobe
//   o_rd_ram    - data-memory read strobe
//   o_halt      - high in HALT
//   o_trap      - undefined-opcode trap flag (only when BIP_TRAP_EN is defined)
// Modports: master = control unit, slave = memory/datapath side.
interface bip_control_if #(
  parameter int unsigned E_BITS  = 16,
  parameter int unsigned D_BITS  = 11,
  parameter int unsigned PC_BITS = 11,
  parameter int unsigned S_BITS  = 2
);
  logic                 i_start;
  logic [E_BITS-1:0]    i_Instr;
  logic [PC_BITS-1:0]   o_Addr_prog;
  logic [D_BITS-1:0]    o_Data;
  logic [S_BITS-1:0]    o_sel_A;
  logic                 o_sel_B;
  logic                 o_op;
  logic                 o_w_acc;
  logic                 o_wr_ram;
  logic                 o_rd_ram;
  logic                 o_halt;
`ifdef BIP_TRAP_EN
  logic                 o_trap;
`endif

  modport master (
    input  i_start, i_Instr,
    output o_Addr_prog, o_Data, o_sel_A, o_sel_B, o_op, o_w_acc, o_wr_ram, o_rd_ram,
`ifdef BIP_TRAP_EN
    output o_trap,
`endif
    output o_halt
  );

  modport slave (
    output i_start, i_Instr,
    input  o_Addr_prog, o_Data, o_sel_A, o_sel_B, o_op, o_w_acc, o_wr_ram, o_rd_ram,
`ifdef BIP_TRAP_EN
    input  o_trap,
`endif
    input  o_halt
  );
endinterface

// File: rtl/bip_control.sv
// Control unit for the accumulator processor: program counter, instruction fetch and decode.
// Ports:
//   i_clock - rising-edge clock
//   i_reset - asynchronous active-low reset
//   bus     - bip_control_if.master (start, instruction in; PC, operand, strobes, halt out)
// Optional feature macro: BIP_TRAP_EN - undefined opcodes halt the core and raise o_trap.
// Without it undefined opcodes execute as NOP.
module bip_control #(
  parameter int unsigned E_BITS  = 16,
  parameter int unsigned OP_BITS = 5,
  parameter int unsigned D_BITS  = 11,
  parameter int unsigned PC_BITS = 11,
  parameter int unsigned S_BITS  = 2
) (
  input  logic          i_clock,
  input  logic          i_reset,
  bip_control_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  localparam logic [OP_BITS-1:0] OpHlt  = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OpSto  = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] OpLd   = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OpLdi  = OP_BITS'(3);
  localparam logic [OP_BITS-1:0] OpAdd  = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] OpAddi = OP_BITS'(5);
  localparam logic [OP_BITS-1:0] OpSub  = OP_BITS'(6);
  localparam logic [OP_BITS-1:0] OpSubi = OP_BITS'(7);

  localparam logic [S_BITS-1:0] SelRam = S_BITS'(0);
  localparam logic [S_BITS-1:0] SelImm = S_BITS'(1);
  localparam logic [S_BITS-1:0] SelAlu = S_BITS'(2);

  state_e             state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [OP_BITS-1:0] opcode;

  assign opcode = bus.i_Instr[E_BITS-1 -: OP_BITS];

`ifdef BIP_TRAP_EN
  logic trap_q, trap_d;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
`ifdef BIP_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef BIP_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
`ifdef BIP_TRAP_EN
    trap_d       = trap_q;
`endif
    bus.o_sel_A  = SelRam;
    bus.o_sel_B  = 1'b0;
    bus.o_op     = 1'b0;
    bus.o_w_acc  = 1'b0;
    bus.o_wr_ram = 1'b0;
    bus.o_rd_ram = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_start) state_d = StRun;
      end
      StRun: begin
        // Wraps naturally at 2^PC_BITS.
        pc_d = pc_q + PC_BITS'(1);
        case (opcode)
          OpHlt: begin
            state_d = StHalt;
            pc_d    = pc_q;
          end
          OpSto: bus.o_wr_ram = 1'b1;
          OpLd: begin
            bus.o_rd_ram = 1'b1;
            bus.o_sel_A  = SelRam;
            bus.o_w_acc  = 1'b1;
          end
          OpLdi: begin
            bus.o_sel_A = SelImm;
            bus.o_w_acc = 1'b1;
          end
          OpAdd, OpSub: begin
            bus.o_rd_ram = 1'b1;
            bus.o_op     = (opcode == OpSub);
            bus.o_sel_A  = SelAlu;
            bus.o_w_acc  = 1'b1;
          end
          OpAddi, OpSubi: begin
            bus.o_sel_B = 1'b1;
            bus.o_op    = (opcode == OpSubi);
            bus.o_sel_A = SelAlu;
            bus.o_w_acc = 1'b1;
          end
          default: begin
`ifdef BIP_TRAP_EN
            state_d = StHalt;
            pc_d    = pc_q;
            trap_d  = 1'b1;
`endif
          end
        endcase
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.o_Addr_prog = pc_q;
  assign bus.o_Data      = bus.i_Instr[D_BITS-1:0];
  assign bus.o_halt      = (state_q == StHalt);
`ifdef BIP_TRAP_EN
  assign bus.o_trap      = trap_q;
`endif

endmodule
